prize_spawn_scheduler: RTL and testbench
========================================

# prize_spawn_scheduler

Sequences prize placement on the 7×10 prize tile grid. A frame-based timer triggers each spawn attempt. The block scans the live prize map through a read port for a FREE tile that Bumpy is not standing on. It then issues a single-cell write request to the prize-map owner using a req/ack handshake. It tracks how many prizes are live, enforces a cap, and flushes on level change or death.

## Interface
- NUM_OF_ROWS, 7, grid rows
- NUM_OF_COLS, 10, grid columns
- SPAWN_PERIOD, 120, frames between spawn attempts at level 0
- MAX_PRIZES, 4, live-prize cap (≤7)
- clk  in  1  clock
- resetN  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse per VGA frame
- enable  in  1  spawning allowed (game running)
- level_restart  in  1  pulse on next level or Bumpy death
- lvl  in  3  current level
- random_value  in  10  free-running random source
- bumpy_x, bumpy_y  in  11  Bumpy position in pixels
- prize_taken  in  1  pulse when a live prize is collected
- rd_row / rd_col  out  3 / 4  map read address (registered)
- rd_type  in  3  map content at rd_row/rd_col, combinational, same cycle
- wr_req  out  1  write request
- wr_row / wr_col / wr_type  out  3 / 4 / 3  write cell and value, stable while wr_req=1
- wr_ack  in  1  map owner accepted the write
- spawn_count  out  3  live prizes
- busy  out  1  high in SEARCH or REQ

## Operation
- States: IDLE, SEARCH, REQ. Reset state is IDLE. All outputs reset to 0.
- Timer: counts frame_start pulses while enable=1 and the state is IDLE. Limit = max(1, SPAWN_PERIOD >> lvl). When timer reaches limit-1 on a frame_start:
  - timer clears.
  - If spawn_count < MAX_PRIZES → go to SEARCH.
  - Otherwise stay in IDLE. The attempt is skipped.
- SEARCH entry latches the start cell:
  - row = random_value[9:5] mod NUM_OF_ROWS
  - col = random_value[4:0] mod NUM_OF_COLS
- SEARCH checks one cell per cycle. The cell is a hit when rd_type==FREE and (row,col) ≠ (bumpy_y>>6, bumpy_x>>6).
  - On a hit: latch the cell, go to REQ.
  - On a miss: advance col. On col wrap, go to col 0 and row+1; on row wrap, go to row 0.
  - After NUM_OF_ROWS*NUM_OF_COLS misses → IDLE with no write.
- REQ: wr_req=1 and the write fields are held until wr_ack. An ack in the first REQ cycle is legal. On ack: spawn_count+1, go to IDLE, wr_req=0 the next cycle.
- spawn_count rules:
  - prize_taken decrements it; it saturates at 0.
  - prize_taken together with ack leaves it unchanged.
- level_restart has highest priority, in any state:
  - next state IDLE; timer, spawn_count and wr_req clear next cycle.
  - An in-flight request is abandoned.
- enable=0 freezes the timer only. An active SEARCH or REQ runs to completion.

## Timing
- Timer expiry at frame_start cycle t → SEARCH at t+1, with the start cell on rd_row/rd_col at t+1.
- Hit found at cycle s → wr_req=1 at s+1.
- Worst-case search is 70 cycles, well inside one frame line.
- wr_ack at cycle a → spawn_count updated at a+1, busy=0 at a+1.
- Reset asserted mid-REQ → wr_req drops asynchronously.

## Configuration
- PRIZE_TYPE_RANDOM_EN defined: wr_type = 1 + (random_value[1:0] mod 3), giving types 1..3, sampled at the hit.
- PRIZE_TYPE_RANDOM_EN undefined: wr_type is always REGU (3'b001).

## Structure
- Shared package prize_pkg holds:
  - FREE/REGU tile constants
  - NUM_OF_ROWS/NUM_OF_COLS defaults
  - enum spawn_state_t {IDLE, SEARCH, REQ}
- Sub-module prize_cell_scanner holds the row/col wrap counter with load, step and a cells-visited terminal flag.

## Test plan
- SPAWN_PERIOD=4, lvl=0, empty map, random_value=10'h000, Bumpy at pixel (200,200) → after the 4th frame_start: wr_req with row 0, col 0, type 1; ack → spawn_count=1.
- Bumpy at (0,0), start cell (0,0) FREE, all other cells FREE → writes (0,1).
- Map full except (6,9), start (0,0) → wr_req at (6,9) exactly 70 cycles after SEARCH entry. Fully full map → return to IDLE, no wr_req, count unchanged.
- spawn_count=MAX_PRIZES=4 and timer expiry → no SEARCH. Then prize_taken → count 3, and the next expiry spawns.
- Hold wr_ack=0 for 5 cycles → wr fields stable. Then assert level_restart → wr_req=0, spawn_count=0, state IDLE next cycle.
- lvl=2, SPAWN_PERIOD=4 → attempt on every frame_start. lvl=3 → limit floors to 1.

Source files
------------

// File: rtl/prize_pkg.sv
// Shared definitions for the prize spawner: tile codes, grid defaults,
// the scheduler state type and the random prize-type helper.
package prize_pkg;

  // Tile content codes as stored in the prize map.
  localparam logic [2:0] FREE = 3'b000;
  localparam logic [2:0] REGU = 3'b001;

  // Default grid geometry.
  localparam int DEF_ROWS = 7;
  localparam int DEF_COLS = 10;

  // Field widths of the map read/write ports.
  localparam int ROW_W  = 3;
  localparam int COL_W  = 4;
  localparam int TYPE_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    REQ    = 2'd2
  } spawn_state_t;

  // Maps two random bits onto the prize types 1..3.
  function automatic logic [TYPE_W-1:0] random_type(input logic [1:0] r);
    logic [1:0] m;
    m = r % 2'd3;
    return 3'd1 + {1'b0, m};
  endfunction

endpackage

// File: rtl/prize_cell_scanner.sv
// Row/column walker over the prize grid. Load sets the start cell and
// clears the visit counter; step moves one column right, wrapping to the
// next row and from the last row back to row 0. last_o is high while the
// current cell is the final one of a full lap.
module prize_cell_scanner
  import prize_pkg::*;
#(
  parameter int NUM_OF_ROWS = DEF_ROWS,
  parameter int NUM_OF_COLS = DEF_COLS
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [ROW_W-1:0] load_row_i,
  input  logic [COL_W-1:0] load_col_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_o
);

  localparam int CELLS = NUM_OF_ROWS * NUM_OF_COLS;
  localparam int CNT_W = $clog2(CELLS);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(NUM_OF_ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(NUM_OF_COLS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELLS - 1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next position: load wins over step, step wraps column then row.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    cnt_d = cnt_q;
    if (load_i) begin
      row_d = load_row_i;
      col_d = load_col_i;
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Position and visit-count registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      row_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      cnt_q <= cnt_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/prize_spawn_scheduler.sv
// Prize spawn scheduler: a frame timer triggers spawn attempts, a grid scan
// finds a FREE tile Bumpy is not standing on, and a req/ack write places the
// prize. Live prizes are counted and capped; level_restart flushes all.
// Build option: define PRIZE_TYPE_RANDOM_EN to pick prize types 1..3 from
// random_value at the hit; otherwise every prize is REGU.
//
// Write handshake: wr_req rises the cycle after a hit and stays high, with
// wr_row/wr_col/wr_type frozen, until the cycle wr_ack is seen high (ack in
// the first request cycle is accepted); wr_req is low the following cycle.
module prize_spawn_scheduler
  import prize_pkg::*;
#(
  parameter int NUM_OF_ROWS  = DEF_ROWS,
  parameter int NUM_OF_COLS  = DEF_COLS,
  parameter int SPAWN_PERIOD = 120,
  parameter int MAX_PRIZES   = 4
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              frame_start,
  input  logic              enable,
  input  logic              level_restart,
  input  logic [2:0]        lvl,
  input  logic [9:0]        random_value,
  input  logic [10:0]       bumpy_x,
  input  logic [10:0]       bumpy_y,
  input  logic              prize_taken,
  output logic [ROW_W-1:0]  rd_row,
  output logic [COL_W-1:0]  rd_col,
  input  logic [TYPE_W-1:0] rd_type,
  output logic              wr_req,
  output logic [ROW_W-1:0]  wr_row,
  output logic [COL_W-1:0]  wr_col,
  output logic [TYPE_W-1:0] wr_type,
  input  logic              wr_ack,
  output logic [2:0]        spawn_count,
  output logic              busy,
  output spawn_state_t      dbg_state
);

  localparam int TMR_W = $clog2(SPAWN_PERIOD + 1);
  localparam logic [TMR_W-1:0] PERIOD_V = TMR_W'(SPAWN_PERIOD);
  localparam logic [2:0]       CAP      = 3'(MAX_PRIZES);

  spawn_state_t      state_q;
  logic [TMR_W-1:0]  timer_q;
  logic [TMR_W-1:0]  period_shr;
  logic [TMR_W-1:0]  limit_m1;
  logic [2:0]        count_q, count_d;
  logic              wr_req_q;
  logic [ROW_W-1:0]  wr_row_q;
  logic [COL_W-1:0]  wr_col_q;
  logic [TYPE_W-1:0] wr_type_q;
  logic [TYPE_W-1:0] hit_type;

  logic [ROW_W-1:0]  scan_row;
  logic [COL_W-1:0]  scan_col;
  logic              scan_last;
  logic              scan_step;

  logic [4:0]        rnd_row_raw;
  logic [4:0]        rnd_col_raw;
  logic [ROW_W-1:0]  start_row;
  logic [COL_W-1:0]  start_col;

  logic              frame_tick;
  logic              timer_expire;
  logic              start_search;
  logic              bumpy_here;
  logic              cell_hit;
  logic              ack_fire;
  logic              unused_pos_bits;

  // Spawn period shrinks with level; a zero result floors to one frame.
  always_comb begin
    period_shr = PERIOD_V >> lvl;
    limit_m1   = (period_shr == '0) ? '0 : period_shr - TMR_W'(1);
  end

  // Random start cell for a new search, reduced into the grid.
  always_comb begin
    rnd_row_raw = random_value[9:5];
    rnd_col_raw = random_value[4:0];
    start_row   = ROW_W'(rnd_row_raw % 5'(NUM_OF_ROWS));
    start_col   = COL_W'(rnd_col_raw % 5'(NUM_OF_COLS));
  end

  // Prize type written on a hit.
  always_comb begin
`ifdef PRIZE_TYPE_RANDOM_EN
    hit_type = random_type(random_value[1:0]);
`else
    hit_type = REGU;
`endif
  end

  // Attempt triggering and the per-cell hit test against the live map.
  always_comb begin
    frame_tick   = (state_q == IDLE) && enable && frame_start;
    timer_expire = (timer_q >= limit_m1);
    start_search = frame_tick && timer_expire && (count_q < CAP) && !level_restart;
    bumpy_here   = ({2'b00, scan_row} == bumpy_y[10:6]) &&
                   ({1'b0, scan_col} == bumpy_x[10:6]);
    cell_hit     = (state_q == SEARCH) && (rd_type == FREE) && !bumpy_here;
    scan_step    = (state_q == SEARCH) && !cell_hit && !scan_last;
    ack_fire     = (state_q == REQ) && wr_ack;
  end

  // Live-prize count: a collection and an accepted write cancel out.
  always_comb begin
    count_d = count_q;
    if (ack_fire && !prize_taken) begin
      count_d = count_q + 3'd1;
    end else if (prize_taken && !ack_fire && (count_q != 3'd0)) begin
      count_d = count_q - 3'd1;
    end
  end

  prize_cell_scanner #(
    .NUM_OF_ROWS(NUM_OF_ROWS),
    .NUM_OF_COLS(NUM_OF_COLS)
  ) u_scanner (
    .clk       (clk),
    .resetN    (resetN),
    .load_i    (start_search),
    .step_i    (scan_step),
    .load_row_i(start_row),
    .load_col_i(start_col),
    .row_o     (scan_row),
    .col_o     (scan_col),
    .last_o    (scan_last)
  );

  // Scheduler FSM with timer, prize count and registered write port.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      count_q   <= '0;
      wr_req_q  <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_type_q <= '0;
    end else if (level_restart) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      count_q  <= '0;
      wr_req_q <= 1'b0;
    end else begin
      count_q <= count_d;
      case (state_q)
        IDLE: begin
          if (frame_tick) begin
            if (timer_expire) begin
              timer_q <= '0;
              if (count_q < CAP) state_q <= SEARCH;
            end else begin
              timer_q <= timer_q + TMR_W'(1);
            end
          end
        end
        SEARCH: begin
          if (cell_hit) begin
            wr_row_q  <= scan_row;
            wr_col_q  <= scan_col;
            wr_type_q <= hit_type;
            wr_req_q  <= 1'b1;
            state_q   <= REQ;
          end else if (scan_last) begin
            state_q <= IDLE;
          end
        end
        REQ: begin
          if (wr_ack) begin
            wr_req_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_row      = scan_row;
  assign rd_col      = scan_col;
  assign wr_req      = wr_req_q;
  assign wr_row      = wr_row_q;
  assign wr_col      = wr_col_q;
  assign wr_type     = wr_type_q;
  assign spawn_count = count_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

  // Sub-tile pixel bits play no part in the cell comparison.
  assign unused_pos_bits = ^{bumpy_x[5:0], bumpy_y[5:0]};

endmodule

// File: tb/tb_prize_spawn_scheduler.sv
// Bench for prize_spawn_scheduler: directed scenarios plus randomized
// attempts, predicted from a grid-level model (linear cell index walk,
// frame counting) and a scoreboard of expected writes.
module tb_prize_spawn_scheduler;
  import prize_pkg::*;

  localparam int ROWS   = 7;
  localparam int COLS   = 10;
  localparam int PERIOD = 4;
  localparam int MAXP   = 4;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        frame_start = 1'b0;
  logic        enable = 1'b1;
  logic        level_restart = 1'b0;
  logic [2:0]  lvl = 3'd0;
  logic [9:0]  random_value = 10'd0;
  logic [10:0] bumpy_x = 11'd200;
  logic [10:0] bumpy_y = 11'd200;
  logic        prize_taken = 1'b0;
  logic [2:0]  rd_row;
  logic [3:0]  rd_col;
  logic [2:0]  rd_type;
  logic        wr_req;
  logic [2:0]  wr_row;
  logic [3:0]  wr_col;
  logic [2:0]  wr_type;
  logic        wr_ack = 1'b0;
  logic [2:0]  spawn_count;
  logic        busy;
  spawn_state_t dbg_state;

  logic [2:0]  map_m [ROWS][COLS];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          model_count = 0;

  prize_spawn_scheduler #(
    .NUM_OF_ROWS(ROWS), .NUM_OF_COLS(COLS),
    .SPAWN_PERIOD(PERIOD), .MAX_PRIZES(MAXP)
  ) dut (
    .clk(clk), .resetN(resetN), .frame_start(frame_start), .enable(enable),
    .level_restart(level_restart), .lvl(lvl), .random_value(random_value),
    .bumpy_x(bumpy_x), .bumpy_y(bumpy_y), .prize_taken(prize_taken),
    .rd_row(rd_row), .rd_col(rd_col), .rd_type(rd_type),
    .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_type(wr_type),
    .wr_ack(wr_ack), .spawn_count(spawn_count), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  // Combinational map read port.
  always_comb begin
    if (rd_row < 3'(ROWS) && rd_col < 4'(COLS)) rd_type = map_m[rd_row][rd_col];
    else rd_type = 3'b111;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame(input logic en);
    enable = en;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    enable = 1'b1;
  endtask

  task automatic map_fill(input logic [2:0] v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) map_m[r][c] = v;
  endtask

  task automatic take_prize();
    prize_taken = 1'b1;
    tick();
    prize_taken = 1'b0;
    if (model_count > 0) model_count--;
    check_val("take_count", spawn_count, model_count);
  endtask

  task automatic restart_dut();
    level_restart = 1'b1;
    tick();
    level_restart = 1'b0;
    model_count = 0;
    exp_q.delete();
    check_val("restart_count", spawn_count, 0);
    check_val("restart_state", dbg_state, IDLE);
  endtask

  function automatic int model_limit();
    int l;
    l = PERIOD >> lvl;
    return (l < 1) ? 1 : l;
  endfunction

  // Index of the first acceptable cell along the wrapped row-major walk.
  function automatic int find_cell(input int sr, input int sc);
    int lin, r, c;
    for (int i = 0; i < ROWS * COLS; i++) begin
      lin = (sr * COLS + sc + i) % (ROWS * COLS);
      r = lin / COLS;
      c = lin % COLS;
      if (map_m[r][c] == FREE && !(r == int'(bumpy_y) / 64 && c == int'(bumpy_x) / 64)) return i;
    end
    return -1;
  endfunction

  // One full spawn attempt starting from a cleared timer.
  task automatic run_attempt(input logic [9:0] rv, input int ack_delay,
                             input bit take_with_ack, input bit abandon);
    int lim, k, sr, sc, lin, er, ec, n;
    logic [1:0] rlo;
    logic [2:0] et;
    logic [31:0] e;
    random_value = rv;
    lim = model_limit();
    sr = int'(rv[9:5]) % ROWS;
    sc = int'(rv[4:0]) % COLS;
    for (int i = 0; i < lim - 1; i++) begin
      if ($urandom_range(0, 3) == 0) pulse_frame(1'b0);
      pulse_frame(1'b1);
    end
    check_val("pre_expiry_idle", busy, 0);
    if ($urandom_range(0, 3) == 0) begin
      pulse_frame(1'b0);
      check_val("frozen_timer", busy, 0);
    end
    pulse_frame(1'b1);
    if (model_count >= MAXP) begin
      check_val("cap_skip", busy, 0);
      return;
    end
    check_val("search_entry", busy, 1);
    check_val("start_row", rd_row, sr);
    check_val("start_col", rd_col, sc);
    k = find_cell(sr, sc);
    if (k < 0) begin
      repeat (ROWS * COLS - 1) tick();
      check_val("search_span", busy, 1);
      tick();
      check_val("search_exhaust", busy, 0);
      check_val("exhaust_no_req", wr_req, 0);
      check_val("exhaust_count", spawn_count, model_count);
      if (busy) restart_dut();
      return;
    end
    lin = (sr * COLS + sc + k) % (ROWS * COLS);
    er = lin / COLS;
    ec = lin % COLS;
    rlo = rv[1:0];
`ifdef PRIZE_TYPE_RANDOM_EN
    et = 3'(1 + int'(rlo) % 3);
`else
    et = REGU;
`endif
    exp_q.push_back({21'd0, 3'(er), 4'(ec), et, 1'b1});
    n = 0;
    while (wr_req !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    check_val("hit_latency", n, k + 1);
    if (wr_req !== 1'b1) begin
      restart_dut();
      return;
    end
    e = exp_q.pop_front();
    check_val("wr_fields", {21'd0, wr_row, wr_col, wr_type, wr_req}, e);
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      check_val("hold_stable", {21'd0, wr_row, wr_col, wr_type, wr_req}, e);
    end
    if (abandon) begin
      level_restart = 1'b1;
      tick();
      level_restart = 1'b0;
      model_count = 0;
      check_val("abandon_req", wr_req, 0);
      check_val("abandon_count", spawn_count, 0);
      check_val("abandon_state", dbg_state, IDLE);
      return;
    end
    wr_ack = 1'b1;
    prize_taken = take_with_ack;
    tick();
    wr_ack = 1'b0;
    prize_taken = 1'b0;
    map_m[er][ec] = et;
    if (!take_with_ack) model_count++;
    check_val("ack_count", spawn_count, model_count);
    check_val("ack_busy", busy, 0);
    check_val("ack_req", wr_req, 0);
  endtask

  initial begin
    int n;
    map_fill(FREE);
    // Reset values.
    #12;
    check_val("rst_wr_req", wr_req, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_count", spawn_count, 0);
    check_val("rst_rd_addr", {rd_row, rd_col}, 0);
    check_val("rst_wr_cell", {wr_row, wr_col, wr_type}, 0);
    check_val("rst_state", dbg_state, IDLE);
    @(posedge clk);
    #1 resetN = 1'b1;
    tick();

    // Empty map, start (0,0), Bumpy far away.
    run_attempt(10'h000, 0, 1'b0, 1'b0);
    // Bumpy on the start cell: next cell along the row.
    map_fill(FREE);
    bumpy_x = 11'd0;
    bumpy_y = 11'd0;
    run_attempt(10'h000, 1, 1'b0, 1'b0);
    // Only the last cell of the lap is free.
    bumpy_x = 11'd200;
    bumpy_y = 11'd200;
    map_fill(REGU);
    map_m[6][9] = FREE;
    run_attempt(10'h000, 0, 1'b0, 1'b0);
    // Full map: lap completes with no write.
    map_fill(REGU);
    run_attempt(10'h000, 0, 1'b0, 1'b0);
    // Reach the cap, skip, collect, spawn again.
    map_fill(FREE);
    run_attempt(10'h2A5, 2, 1'b0, 1'b0);
    run_attempt(10'h111, 0, 1'b0, 1'b0);
    take_prize();
    run_attempt(10'h3FF, 0, 1'b0, 1'b0);
    // Held request then abandoned by level_restart.
    take_prize();
    run_attempt(10'h155, 5, 1'b0, 1'b1);
    take_prize();
    // Collection coinciding with the accepted write.
    run_attempt(10'h0C3, 2, 1'b1, 1'b0);
    run_attempt(10'h07E, 0, 1'b0, 1'b0);
    // Shorter periods at higher levels.
    restart_dut();
    lvl = 3'd2;
    run_attempt(10'h031, 0, 1'b0, 1'b0);
    lvl = 3'd3;
    run_attempt(10'h1E2, 1, 1'b0, 1'b0);
    lvl = 3'd1;
    run_attempt(10'h2B4, 0, 1'b0, 1'b0);

    // Randomized attempts.
    for (int it = 0; it < 24; it++) begin
      int dens;
      if ($urandom_range(0, 4) == 0) begin
        restart_dut();
        lvl = 3'($urandom_range(0, 7));
      end
      dens = $urandom_range(0, 100);
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          map_m[r][c] = ($urandom_range(0, 99) < dens) ? REGU : FREE;
      bumpy_x = 11'($urandom_range(0, 639));
      bumpy_y = 11'($urandom_range(0, 447));
      if ($urandom_range(0, 2) == 0) take_prize();
      run_attempt(10'($urandom_range(0, 1023)), $urandom_range(0, 3),
                  ($urandom_range(0, 5) == 0), 1'b0);
    end

    // Reset asserted mid-request drops wr_req without a clock edge.
    restart_dut();
    map_fill(FREE);
    lvl = 3'd3;
    random_value = 10'h000;
    pulse_frame(1'b1);
    n = 0;
    while (wr_req !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    check_val("pre_reset_req", wr_req, 1);
    #2 resetN = 1'b0;
    #1;
    check_val("async_reset_req", wr_req, 0);
    check_val("async_reset_busy", busy, 0);
    @(posedge clk);
    #1 resetN = 1'b1;

    check_val("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
